stream_eq_checker: RTL and testbench
====================================

STREAM_EQ_CHECKER -- requirements
Module: stream_eq_checker

Interface
REQ-001 Parameter: DATA_W, 8, width of each compared stream token.
REQ-002 Parameter: DEPTH, 4, per-side skid FIFO depth; power of two, >=2.
REQ-003 Parameter: CNT_W, 16, width of token counters and num_tokens.
REQ-004 Parameter: TIMEOUT, 255, max consecutive RUN cycles without a compare before declaring a stall; >=1.
REQ-005 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-006 The ports SHALL be as follows (name, direction, width, meaning):
- ap_clk, in, 1: single clock; all state on rising edge.
- ap_rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: pulse; begins a check run (honoured in IDLE, PASS, FAIL).
- num_tokens, in, CNT_W: tokens expected per side; sampled on start.
- a_tdata / a_tvalid / a_tready, in / in / out, DATA_W / 1 / 1: stream A (spec model output), AXI-Stream sink.
- b_tdata / b_tvalid / b_tready, in / in / out, DATA_W / 1 / 1: stream B (implementation output), AXI-Stream sink.
- run, out, 1: high in RUN; clock-enable for both designs under test.
- done, out, 1: high in PASS or FAIL.
- pass, out, 1: high in PASS only.
- mismatch, out, 1: FAIL caused by data miscompare.
- timeout, out, 1: FAIL caused by stall.
- match_cnt, out, CNT_W: tokens compared equal this run.
- mis_a / mis_b, out, DATA_W each: head values of A and B at the first miscompare.

Function
REQ-007 FSM states: IDLE, RUN, PASS, FAIL.
REQ-008 State transitions:
- IDLE/PASS/FAIL + start -> RUN.
- RUN + match_cnt reaching the latched count -> PASS.
- RUN + miscompare or stall -> FAIL.
- start is ignored in RUN.
REQ-009 On entering RUN, the block SHALL:
- clear both FIFOs, match_cnt, the accept counters, the idle counter, mismatch, timeout, mis_a and mis_b;
- latch num_tokens.
REQ-010 If the latched num_tokens is 0, the FSM SHALL go RUN -> PASS on the first RUN cycle and accept no tokens.
REQ-011 Tready SHALL be driven as x_tready = run & FIFO_x not full & acc_x < latched count; it is purely registered-state based, with no combinational path from tvalid or tdata.
REQ-012 A token SHALL be accepted on a side on each edge where x_tvalid & x_tready, and acc_x SHALL increment by 1.
REQ-013 When a FIFO is full, a same-cycle pop SHALL NOT free a slot for a same-cycle push (no bypass).
REQ-014 Compare rule:
- A compare occurs in any RUN cycle where both FIFOs are non-empty; it pops both heads at the edge.
- Equal heads -> match_cnt increments at that edge.
- Unequal heads -> FAIL, mismatch=1, mis_a/mis_b capture the heads, match_cnt is unchanged.
REQ-015 Minimum latency: a token accepted on both sides at edge t SHALL be compared at edge t+1; pass/done rise at edge t+1 when it is the final token.
REQ-016 Stall rule:
- The idle counter increments each RUN cycle without a compare and clears on a compare.
- When it reaches TIMEOUT, the FSM SHALL enter FAIL with timeout=1.
- If a compare occurs in the same cycle, the compare result takes priority.
REQ-017 Tokens SHALL never be accepted outside RUN; on leaving RUN, FIFO contents are held but ignored.
REQ-018 Counters SHALL saturate rather than wrap; num_tokens is limited to 2^CNT_W-1.
REQ-019 done, pass, mismatch, timeout, match_cnt, mis_a and mis_b SHALL hold their values in PASS/FAIL until the next start.

Reset
REQ-020 Assertion of ap_rst_n=0 SHALL immediately clear all of the following, regardless of state:
- FSM -> IDLE;
- run, done, pass, mismatch, timeout, a_tready, b_tready = 0;
- match_cnt, mis_a, mis_b, FIFO pointers and all counters = 0.
REQ-021 Reset asserted mid-RUN SHALL discard all buffered tokens.
REQ-022 The first start after deassertion SHALL be honoured on the first rising edge.

Verification
REQ-023 num_tokens=4; A and B both send 0x11,0x22,0x33,0x44 every cycle -> match_cnt=4, pass=1, done=1 one cycle after the 4th accept, mismatch=0.
REQ-024 num_tokens=3; A sends 0x05,0x06,0x07; B sends 0x05,0x16,0x07 -> FAIL after the 2nd compare, mismatch=1, mis_a=0x06, mis_b=0x16, match_cnt=1.
REQ-025 DEPTH=4, num_tokens=8; A sends 8 tokens back-to-back, B idle for 10 cycles and then sends -> a_tready=0 after 4 A tokens; final pass=1, match_cnt=8.
REQ-026 TIMEOUT=20, num_tokens=2; only A sends -> timeout=1, done=1, pass=0 exactly 20 idle RUN cycles later.
REQ-027 num_tokens=0; start -> pass=1 on the second edge, a_tready and b_tready never asserted.
REQ-028 ap_rst_n pulsed low mid-RUN with 2 tokens buffered, then start with num_tokens=1 and one equal token per side -> all outputs 0 during reset; match_cnt=1, pass=1 after the new run.

Source files
------------

// File: rtl/stream_eq_checker.sv
// Compares two AXI-Stream token sequences head-to-head through per-side skid FIFOs.
// Reports PASS once the expected number of tokens match, or FAIL on miscompare or stall.
module stream_eq_checker #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_tokens,
  input  logic [DATA_W-1:0] a_tdata,
  input  logic              a_tvalid,
  output logic              a_tready,
  input  logic [DATA_W-1:0] b_tdata,
  input  logic              b_tvalid,
  output logic              b_tready,
  output logic              run,
  output logic              done,
  output logic              pass,
  output logic              mismatch,
  output logic              timeout,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [DATA_W-1:0] mis_a,
  output logic [DATA_W-1:0] mis_b
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt_lat;
  logic [CNT_W-1:0]    acc_a, acc_b;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [PTR_W:0]      a_wr, a_rd, b_wr, b_rd;
  logic [DATA_W-1:0]   a_mem [DEPTH];
  logic [DATA_W-1:0]   b_mem [DEPTH];

  logic                a_full, b_full, a_empty, b_empty;
  logic                a_push, b_push, cmp, equal, stall;
  logic [DATA_W-1:0]   a_head, b_head;
  logic [CNT_W-1:0]    match_next;

  assign a_full  = (a_wr[PTR_W] != a_rd[PTR_W]) && (a_wr[PTR_W-1:0] == a_rd[PTR_W-1:0]);
  assign b_full  = (b_wr[PTR_W] != b_rd[PTR_W]) && (b_wr[PTR_W-1:0] == b_rd[PTR_W-1:0]);
  assign a_empty = (a_wr == a_rd);
  assign b_empty = (b_wr == b_rd);

  // Ready depends only on registered state; the full check also rules out pop-to-push bypass.
  assign a_tready = run && !a_full && (acc_a < cnt_lat);
  assign b_tready = run && !b_full && (acc_b < cnt_lat);
  assign a_push   = a_tvalid && a_tready;
  assign b_push   = b_tvalid && b_tready;

  assign a_head     = a_mem[a_rd[PTR_W-1:0]];
  assign b_head     = b_mem[b_rd[PTR_W-1:0]];
  assign cmp        = run && !a_empty && !b_empty;
  assign equal      = (a_head == b_head);
  assign match_next = (cmp && equal && (match_cnt != '1)) ? match_cnt + 1'b1 : match_cnt;
  assign stall      = !cmp && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge ap_clk) begin
    if (a_push) a_mem[a_wr[PTR_W-1:0]] <= a_tdata;
    if (b_push) b_mem[b_wr[PTR_W-1:0]] <= b_tdata;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      run       <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      mismatch  <= 1'b0;
      timeout   <= 1'b0;
      match_cnt <= '0;
      mis_a     <= '0;
      mis_b     <= '0;
      cnt_lat   <= '0;
      acc_a     <= '0;
      acc_b     <= '0;
      idle_cnt  <= '0;
      a_wr      <= '0;
      a_rd      <= '0;
      b_wr      <= '0;
      b_rd      <= '0;
    end else begin
      case (state)
        IDLE, PASS, FAIL: begin
          if (start) begin
            state     <= RUN;
            run       <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            mismatch  <= 1'b0;
            timeout   <= 1'b0;
            match_cnt <= '0;
            mis_a     <= '0;
            mis_b     <= '0;
            cnt_lat   <= num_tokens;
            acc_a     <= '0;
            acc_b     <= '0;
            idle_cnt  <= '0;
            a_wr      <= '0;
            a_rd      <= '0;
            b_wr      <= '0;
            b_rd      <= '0;
          end
        end
        RUN: begin
          if (a_push) begin
            a_wr  <= a_wr + 1'b1;
            acc_a <= acc_a + 1'b1;
          end
          if (b_push) begin
            b_wr  <= b_wr + 1'b1;
            acc_b <= acc_b + 1'b1;
          end
          if (cmp) begin
            a_rd <= a_rd + 1'b1;
            b_rd <= b_rd + 1'b1;
          end
          // Compare outcome outranks completion, which outranks the stall timer.
          if (cmp && !equal) begin
            state    <= FAIL;
            run      <= 1'b0;
            done     <= 1'b1;
            mismatch <= 1'b1;
            mis_a    <= a_head;
            mis_b    <= b_head;
          end else if (match_next == cnt_lat) begin
            state     <= PASS;
            run       <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b1;
            match_cnt <= match_next;
          end else if (stall) begin
            state   <= FAIL;
            run     <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            match_cnt <= match_next;
            idle_cnt  <= cmp ? '0 : idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_eq_checker.sv
// Directed self-checking bench for stream_eq_checker (DEPTH=4, TIMEOUT=20).
module tb_stream_eq_checker;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_tokens = '0;
  logic [7:0]  a_tdata = '0, b_tdata = '0;
  logic        a_tvalid = 1'b0, b_tvalid = 1'b0;
  logic        a_tready, b_tready;
  logic        run, done, pass, mismatch, timeout;
  logic [15:0] match_cnt;
  logic [7:0]  mis_a, mis_b;

  int checks = 0;
  int errors = 0;

  stream_eq_checker #(.DATA_W(8), .DEPTH(4), .CNT_W(16), .TIMEOUT(20)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .num_tokens(num_tokens),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready),
    .run(run), .done(done), .pass(pass), .mismatch(mismatch), .timeout(timeout),
    .match_cnt(match_cnt), .mis_a(mis_a), .mis_b(mis_b)
  );

  always #5 ap_clk = ~ap_clk;

  // Leaves time 1 unit after the edge that sampled start (edge 0 of the run).
  task automatic do_start(input int n);
    start = 1'b1;
    num_tokens = 16'(n);
    @(posedge ap_clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_streams(input logic [7:0] av [8], input logic [7:0] bv [8],
                               input int na, input int nb, input int b_delay, input int budget,
                               output int done_edge, output int a_block, output bit ready_seen);
    int ia, ib, cyc;
    bit fa, fb;
    ia = 0; ib = 0; cyc = 0;
    done_edge = -1; a_block = -1; ready_seen = 1'b0;
    while (cyc < budget && done_edge < 0) begin
      a_tvalid = (ia < na);
      a_tdata  = (ia < na) ? av[ia] : 8'h00;
      b_tvalid = (cyc >= b_delay) && (ib < nb);
      b_tdata  = (ib < nb) ? bv[ib] : 8'h00;
      @(negedge ap_clk);
      fa = a_tvalid && a_tready;
      fb = b_tvalid && b_tready;
      if (a_tready || b_tready) ready_seen = 1'b1;
      if (a_tvalid && !a_tready && ia > 0 && a_block < 0) a_block = ia;
      @(posedge ap_clk); #1;
      cyc++;
      if (fa) ia++;
      if (fb) ib++;
      if (done) done_edge = cyc;
    end
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({run, done, pass, mismatch, timeout, a_tready, b_tready} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b exp 0000000", {run, done, pass, mismatch, timeout, a_tready, b_tready});
    end
    checks++; if ({match_cnt, mis_a, mis_b} !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_values: got %h exp 0", {match_cnt, mis_a, mis_b});
    end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_equal_stream();
    logic [7:0] av [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0};
    int de, ab; bit rs;
    do_start(4);
    checks++; if (run !== 1'b1) begin errors++; $display("[TB] FAIL eq_run: got %b exp 1", run); end
    drive_streams(av, av, 4, 4, 0, 30, de, ab, rs);
    checks++; if (de !== 5) begin errors++; $display("[TB] FAIL eq_done_edge: got %0d exp 5", de); end
    checks++; if ({pass, mismatch, timeout, run} !== 4'b1000) begin
      errors++; $display("[TB] FAIL eq_flags: got %b exp 1000", {pass, mismatch, timeout, run});
    end
    checks++; if (match_cnt !== 16'd4) begin errors++; $display("[TB] FAIL eq_match_cnt: got %0d exp 4", match_cnt); end
    repeat (3) @(posedge ap_clk); #1;
    checks++; if ({done, pass, match_cnt} !== {2'b11, 16'd4}) begin
      errors++; $display("[TB] FAIL eq_hold: got %b/%b/%0d exp 1/1/4", done, pass, match_cnt);
    end
  endtask

  task automatic test_mismatch();
    logic [7:0] av [8] = '{8'h05, 8'h06, 8'h07, 0, 0, 0, 0, 0};
    logic [7:0] bv [8] = '{8'h05, 8'h16, 8'h07, 0, 0, 0, 0, 0};
    int de, ab; bit rs;
    do_start(3);
    drive_streams(av, bv, 3, 3, 0, 30, de, ab, rs);
    checks++; if (de !== 3) begin errors++; $display("[TB] FAIL mis_done_edge: got %0d exp 3", de); end
    checks++; if ({pass, mismatch, timeout} !== 3'b010) begin
      errors++; $display("[TB] FAIL mis_flags: got %b exp 010", {pass, mismatch, timeout});
    end
    checks++; if ({mis_a, mis_b} !== 16'h0616) begin errors++; $display("[TB] FAIL mis_heads: got %h exp 0616", {mis_a, mis_b}); end
    checks++; if (match_cnt !== 16'd1) begin errors++; $display("[TB] FAIL mis_match_cnt: got %0d exp 1", match_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    int de, ab; bit rs;
    do_start(8);
    drive_streams(av, av, 8, 8, 10, 60, de, ab, rs);
    checks++; if (ab !== 4) begin errors++; $display("[TB] FAIL b2b_a_block: got %0d exp 4", ab); end
    checks++; if (de !== 19) begin errors++; $display("[TB] FAIL b2b_done_edge: got %0d exp 19", de); end
    checks++; if ({pass, mismatch, timeout} !== 3'b100) begin
      errors++; $display("[TB] FAIL b2b_flags: got %b exp 100", {pass, mismatch, timeout});
    end
    checks++; if (match_cnt !== 16'd8) begin errors++; $display("[TB] FAIL b2b_match_cnt: got %0d exp 8", match_cnt); end
  endtask

  task automatic test_timeout();
    logic [7:0] av [8] = '{8'h31, 8'h32, 0, 0, 0, 0, 0, 0};
    int de, ab; bit rs;
    do_start(2);
    drive_streams(av, av, 2, 0, 0, 40, de, ab, rs);
    checks++; if (de !== 20) begin errors++; $display("[TB] FAIL to_done_edge: got %0d exp 20", de); end
    checks++; if ({done, pass, mismatch, timeout} !== 4'b1001) begin
      errors++; $display("[TB] FAIL to_flags: got %b exp 1001", {done, pass, mismatch, timeout});
    end
    checks++; if (match_cnt !== 16'd0) begin errors++; $display("[TB] FAIL to_match_cnt: got %0d exp 0", match_cnt); end
  endtask

  task automatic test_zero_tokens();
    logic [7:0] av [8] = '{8'h77, 8'h78, 0, 0, 0, 0, 0, 0};
    int de, ab; bit rs;
    do_start(0);
    drive_streams(av, av, 2, 2, 0, 5, de, ab, rs);
    checks++; if (de !== 1) begin errors++; $display("[TB] FAIL zero_done_edge: got %0d exp 1", de); end
    checks++; if ({pass, rs} !== 2'b10) begin errors++; $display("[TB] FAIL zero_pass_ready: got %b exp 10", {pass, rs}); end
    checks++; if (match_cnt !== 16'd0) begin errors++; $display("[TB] FAIL zero_match_cnt: got %0d exp 0", match_cnt); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] av [8] = '{8'h01, 8'h02, 0, 0, 0, 0, 0, 0};
    logic [7:0] nv [8] = '{8'h5A, 0, 0, 0, 0, 0, 0, 0};
    int de, ab; bit rs;
    do_start(4);
    drive_streams(av, av, 2, 0, 0, 3, de, ab, rs);
    #2 ap_rst_n = 1'b0;
    #1;
    checks++; if ({run, done, pass, mismatch, timeout, a_tready, b_tready} !== 7'b0) begin
      errors++; $display("[TB] FAIL rst_mid_flags: got %b exp 0000000", {run, done, pass, mismatch, timeout, a_tready, b_tready});
    end
    checks++; if ({match_cnt, mis_a, mis_b} !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_mid_values: got %h exp 0", {match_cnt, mis_a, mis_b});
    end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    do_start(1);
    drive_streams(nv, nv, 1, 1, 0, 20, de, ab, rs);
    checks++; if (de !== 2) begin errors++; $display("[TB] FAIL rst_new_done_edge: got %0d exp 2", de); end
    checks++; if ({pass, mismatch, match_cnt} !== {2'b10, 16'd1}) begin
      errors++; $display("[TB] FAIL rst_new_result: got %b/%b/%0d exp 1/0/1", pass, mismatch, match_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_equal_stream();
    test_mismatch();
    test_back_to_back();
    test_timeout();
    test_zero_tokens();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
